eprom_read_arbiter: RTL
=======================

// Module: eprom_read_arbiter
// PURPOSE
//  Shares one 16Kx8 EPROM between two read requesters, e.g. two ABC-style classifier units, using round-robin.
//  Latches the requester's address, drives the EPROM select and read-enable lines, and waits WAIT_CYCLES access cycles.
//  Captures the EPROM byte, returns it on rdata and acks the owner with a 1-cycle pulse.
//  Sits between the consumer modules and eprom_16Kx8.
// PARAMETERS
//  ADDR_W       16  address width (EPROM addr bus)
//  DATA_W        8  data width (EPROM data bus)
//  WAIT_CYCLES   2  extra cycles the address is held before data is sampled (0 allowed)
// PORTS
//  clock       in   1       system clock, all state on posedge
//  reset       in   1       synchronous, active-high reset
//  req0        in   1       requester 0 read request (level)
//  addr0       in   ADDR_W  requester 0 address, must be valid while req0=1
//  req1        in   1       requester 1 read request (level)
//  addr1       in   ADDR_W  requester 1 address, must be valid while req1=1
//  ack0        out  1       1-cycle pulse: rdata holds requester 0's byte
//  ack1        out  1       1-cycle pulse: rdata holds requester 1's byte
//  rdata       out  DATA_W  last byte read, held until next capture
//  grant       out  2       one-hot owner during ACCESS/DONE, 2'b00 in IDLE
//  eprom_addr  out  ADDR_W  EPROM address
//  eprom_data  in   DATA_W  EPROM data
//  eprom_s_    out  1       EPROM select, active low
//  eprom_mr_   out  1       EPROM read enable, active low
// BEHAVIOUR
//  Reset values (sync, at edge with reset=1):
//   - state=IDLE; ack0=ack1=0; grant=0; rdata=0
//   - eprom_addr=0; eprom_s_=eprom_mr_=1; last_grant=1, so requester 0 wins the first tie.
//  Reset overrides everything.
//   - Reset mid-transaction aborts it, with no ack issued.
//   - Pending reqs are re-arbitrated from IDLE after reset drops.
//  FSM:
//   - IDLE:
//     - No req: stay, s_/mr_=1, eprom_addr holds last value.
//     - One req: grant it.
//     - Both: grant the one != last_grant.
//     - On grant: latch addrX into eprom_addr, set grant/last_grant, load cnt=WAIT_CYCLES, go ACCESS.
//   - ACCESS:
//     - s_=mr_=0, eprom_addr stable.
//     - cnt!=0: cnt--.
//     - cnt==0: rdata<=eprom_data, go DONE.
//     - Lasts WAIT_CYCLES+1 cycles.
//   - DONE:
//     - ackX=1 for the owner for exactly 1 cycle; s_=mr_=1; go IDLE.
//     - grant still shows the owner; cleared in IDLE.
//  Latency and throughput:
//   - req sampled at edge E0 -> ack high from edge E0+WAIT_CYCLES+2 for 1 cycle.
//   - Throughput: 1 transaction per WAIT_CYCLES+3 cycles.
//  Handshake:
//   - Requester holds reqX and addrX until ackX.
//   - addrX may change after the grant edge, because the address is latched.
//   - reqX still 1 in the IDLE cycle after DONE = new request, so back-to-back reads are legal.
//   - Under dual continuous load, grants strictly alternate 0,1,0,1.
//  Requests arriving during ACCESS/DONE are ignored until IDLE, with no queueing beyond the req level.
//  Ack rules:
//   - ack0 and ack1 are never both 1.
//   - ackX never occurs without a prior grant to X.
//  cnt width = clog2(WAIT_CYCLES+1), minimum 1.
// TESTING
//  1. Reset with req0=1 held -> all outputs at reset values. After reset drops, 1st grant=2'b01 and ack0 at E0+4 (WAIT=2).
//  2. req0 only, addr0=16'h0005, EPROM byte 8'h42 -> eprom_s_/mr_ low 3 cycles, rdata=8'h42, ack0 1-cycle pulse, ack1 stays 0.
//  3. req0=req1=1 continuously -> acks alternate ack0,ack1,ack0,... exactly 5 cycles apart, each rdata matching its own address.
//  4. req1 alone, then req0 raised during ACCESS -> req0 served only after ack1; no glitch on eprom_addr during ACCESS.
//  5. reset pulsed in ACCESS cycle 2 -> no ack, s_/mr_=1 next cycle, pending req re-granted after release.
//  6. WAIT_CYCLES=0 build -> ACCESS 1 cycle, ack at E0+2, period 3 cycles.

Source files
------------

// File: rtl/eprom_read_arbiter.sv
// Round-robin read arbiter sharing one EPROM between two requesters.
// Latches the winner's address, holds select/read low for WAIT_CYCLES+1 cycles, then acks.
module eprom_read_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        grant,
    output logic [ADDR_W-1:0] eprom_addr,
    input  logic [DATA_W-1:0] eprom_data,
    output logic              eprom_s_,
    output logic              eprom_mr_
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_grant_q;
    logic             pick1;

    // On a tie, the requester that did not win last time goes next.
    always_comb begin
        pick1 = req1 && (!req0 || !last_grant_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            grant        <= 2'b00;
            rdata        <= '0;
            eprom_addr   <= '0;
            eprom_s_     <= 1'b1;
            eprom_mr_    <= 1'b1;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        eprom_addr   <= pick1 ? addr1 : addr0;
                        grant        <= pick1 ? 2'b10 : 2'b01;
                        last_grant_q <= pick1;
                        cnt_q        <= CNT_LOAD;
                        eprom_s_     <= 1'b0;
                        eprom_mr_    <= 1'b0;
                        state_q      <= StAccess;
                    end
                end
                StAccess: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rdata     <= eprom_data;
                        eprom_s_  <= 1'b1;
                        eprom_mr_ <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    // Ack pulse becomes visible together with the return to idle.
                    ack0    <= grant[0];
                    ack1    <= grant[1];
                    grant   <= 2'b00;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
